// File: rtl/rv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rv_pkg
// Purpose  : Shared store-path constants and drain FSM encoding.
// Revision : 1.0 - initial release
// ============================================================================
package rv_pkg;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    localparam int DEPTH_DEFAULT = 4;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } drain_state_t;

endpackage
`default_nettype wire

// File: rtl/store_lane_align.sv
`default_nettype none
// ============================================================================
// Module   : store_lane_align
// Purpose  : Places store data on byte lanes, builds byte enables, flags
//            misaligned or illegal store sizes.
// Revision : 1.0 - initial release
// ============================================================================
module store_lane_align
    import rv_pkg::*;
(
    input  logic [31:0] st_data,
    input  logic [1:0]  size,
    input  logic [1:0]  off,
    output logic [31:0] wdata,
    output logic [3:0]  be,
    output logic        misalign
);

    always_comb begin
        wdata    = st_data;
        be       = 4'b0000;
        misalign = 1'b0;
        case (size)
            SZ_B: begin
                be    = 4'b0001 << off;
                wdata = {4{st_data[7:0]}};
            end
            SZ_H: begin
                be       = 4'b0011 << off;
                wdata    = {2{st_data[15:0]}};
                misalign = off[0];
            end
            SZ_W: begin
                be       = 4'b1111;
                misalign = (off != 2'b00);
            end
            default: misalign = 1'b1;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/store_buffer.sv
`default_nettype none
// ============================================================================
// Module   : store_buffer
// Purpose  : In-order store queue draining to data memory over req/ack, with
//            misalign reporting and load-after-store word hazard detection.
// Revision : 1.0 - initial release
// ============================================================================
module store_buffer
    import rv_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          st_valid,
    output logic          st_ready,
    input  logic [AW-1:0] st_addr,
    input  logic [DW-1:0] st_data,
    input  logic [2:0]    st_funct3,
    output logic          st_misalign,
    input  logic          ld_valid,
    input  logic [AW-1:0] ld_addr,
    output logic          ld_hazard,
    output logic          mem_req,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic [3:0]    mem_be,
    input  logic          mem_ack,
    output logic          empty
);

    localparam int          PW     = $clog2(DEPTH);
    localparam int          WAW    = AW - 2;
    localparam logic [PW:0] C_FULL = (PW+1)'(DEPTH);

    logic [WAW-1:0] r_ent_addr [DEPTH];
    logic [DW-1:0]  r_ent_data [DEPTH];
    logic [3:0]     r_ent_be   [DEPTH];

    logic [PW-1:0]  r_wr_ptr;
    logic [PW-1:0]  r_rd_ptr;
    logic [PW:0]    r_count;
    logic [PW:0]    w_count_next;
    drain_state_t   r_state;
    drain_state_t   w_state_next;
    logic           r_st_misalign;

    logic [DW-1:0]  w_wdata;
    logic [3:0]     w_be;
    logic           w_misalign;
    logic           w_push;
    logic           w_pop;
    logic [DEPTH-1:0] w_hit;
    logic           w_unused_bits;

    store_lane_align u_align (
        .st_data  (st_data),
        .size     (st_funct3[1:0]),
        .off      (st_addr[1:0]),
        .wdata    (w_wdata),
        .be       (w_be),
        .misalign (w_misalign)
    );

    assign w_unused_bits = ^{st_funct3[2], ld_addr[1:0]};

    assign st_ready    = (r_count != C_FULL);
    assign empty       = (r_count == '0);
    assign st_misalign = r_st_misalign;

    assign w_push = st_valid && st_ready && !w_misalign;
    assign w_pop  = (r_state == ST_REQ) && mem_ack;

    always_comb begin
        w_count_next = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + 1'b1;
            2'b01:   w_count_next = r_count - 1'b1;
            default: w_count_next = r_count;
        endcase
    end

    // Entry payload is not reset; occupancy is tracked by pointers and count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_ent_addr[r_wr_ptr] <= st_addr[AW-1:2];
            r_ent_data[r_wr_ptr] <= w_wdata;
            r_ent_be[r_wr_ptr]   <= w_be;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
            r_state       <= ST_IDLE;
            r_st_misalign <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count       <= w_count_next;
            r_state       <= w_state_next;
            r_st_misalign <= st_valid && w_misalign;
        end
    end

    always_comb begin
        w_state_next = r_state;
        mem_req      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_count != '0) w_state_next = ST_REQ;
            end
            ST_REQ: begin
                mem_req = 1'b1;
                if (mem_ack && (w_count_next == '0)) w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    assign mem_addr  = {r_ent_addr[r_rd_ptr], 2'b00};
    assign mem_wdata = r_ent_data[r_rd_ptr];
    assign mem_be    = r_ent_be[r_rd_ptr];

    // An entry is live when its distance from the head is below the count.
    for (genvar i = 0; i < DEPTH; i++) begin : g_hazard
        logic [PW-1:0] w_rel;
        assign w_rel    = PW'(i) - r_rd_ptr;
        assign w_hit[i] = ({1'b0, w_rel} < r_count) && (r_ent_addr[i] == ld_addr[AW-1:2]);
    end

    assign ld_hazard = ld_valid && (|w_hit);

endmodule
`default_nettype wire

// File: tb/tb_store_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_store_buffer
// Purpose  : Self-checking bench: vector table plus scoreboard of memory writes.
// Revision : 1.0 - initial release
// ============================================================================
module tb_store_buffer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        st_valid;
    logic        st_ready;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic [2:0]  st_funct3;
    logic        st_misalign;
    logic        ld_valid;
    logic [31:0] ld_addr;
    logic        ld_hazard;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic        empty;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [2:0]  f3;
        logic        mis;
        logic [3:0]  be;
        logic [31:0] wdata;
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } exp_t;

    vec_t vecs [10];
    exp_t sb_q [$];

    always #5 clk = ~clk;

    store_buffer #(.DEPTH(4), .AW(32), .DW(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .st_valid    (st_valid),
        .st_ready    (st_ready),
        .st_addr     (st_addr),
        .st_data     (st_data),
        .st_funct3   (st_funct3),
        .st_misalign (st_misalign),
        .ld_valid    (ld_valid),
        .ld_addr     (ld_addr),
        .ld_hazard   (ld_hazard),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_be      (mem_be),
        .mem_ack     (mem_ack),
        .empty       (empty)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Every accepted write is compared against the oldest expected entry.
    always @(negedge clk) begin
        if (rst_n && mem_req && mem_ack) begin
            if (sb_q.size() == 0) begin
                check("unexpected_write", mem_addr, 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("wr_addr", mem_addr, e.addr);
                check("wr_data", mem_wdata, e.wdata);
                check("wr_be", {28'd0, mem_be}, {28'd0, e.be});
            end
        end
    end

    task automatic push_exp(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] be);
        exp_t e;
        e.addr  = {addr[31:2], 2'b00};
        e.wdata = wdata;
        e.be    = be;
        sb_q.push_back(e);
    endtask

    task automatic wait_idle(input string name);
        bit done = 1'b0;
        for (int k = 0; k < 20 && !done; k++) begin
            @(negedge clk);
            if (empty && !mem_req) done = 1'b1;
        end
        check(name, {31'd0, done}, 32'd1);
    endtask

    task automatic apply_vec(input vec_t v);
        @(posedge clk); #1;
        st_valid  = 1'b1;
        st_addr   = v.addr;
        st_data   = v.data;
        st_funct3 = v.f3;
        if (!v.mis) push_exp(v.addr, v.wdata, v.be);
        @(posedge clk); #1;
        st_valid = 1'b0;
        @(negedge clk);
        check("misalign", {31'd0, st_misalign}, {31'd0, v.mis});
        check("empty_after_store", {31'd0, empty}, {31'd0, v.mis});
        @(negedge clk);
        check("misalign_pulse_end", {31'd0, st_misalign}, 32'd0);
        if (v.mis) check("no_req_on_reject", {31'd0, mem_req}, 32'd0);
        wait_idle("drain_vec");
    endtask

    initial begin
        vecs[0] = '{32'h0000_0103, 32'h0000_00AB, 3'b000, 1'b0, 4'b1000, 32'hABAB_ABAB};
        vecs[1] = '{32'h0000_0202, 32'hFFFF_F0EE, 3'b001, 1'b0, 4'b1100, 32'hF0EE_F0EE};
        vecs[2] = '{32'h0000_0101, 32'h1234_5678, 3'b010, 1'b1, 4'b0000, 32'h0};
        vecs[3] = '{32'h0000_0000, 32'h1234_5678, 3'b011, 1'b1, 4'b0000, 32'h0};
        vecs[4] = '{32'h0000_0300, 32'h1234_5678, 3'b100, 1'b0, 4'b0001, 32'h7878_7878};
        vecs[5] = '{32'h0000_0301, 32'h0000_BEEF, 3'b001, 1'b1, 4'b0000, 32'h0};
        vecs[6] = '{32'h0000_0304, 32'hDEAD_BEEF, 3'b010, 1'b0, 4'b1111, 32'hDEAD_BEEF};
        vecs[7] = '{32'h0000_0300, 32'h0000_ABCD, 3'b001, 1'b0, 4'b0011, 32'hABCD_ABCD};
        vecs[8] = '{32'h0000_0305, 32'h0000_005A, 3'b000, 1'b0, 4'b0010, 32'h5A5A_5A5A};
        vecs[9] = '{32'h0000_030A, 32'h0000_0001, 3'b010, 1'b1, 4'b0000, 32'h0};

        rst_n     = 1'b0;
        st_valid  = 1'b0;
        st_addr   = '0;
        st_data   = '0;
        st_funct3 = '0;
        ld_valid  = 1'b1;
        ld_addr   = '0;
        mem_ack   = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_mem_req", {31'd0, mem_req}, 32'd0);
        check("rst_empty", {31'd0, empty}, 32'd1);
        check("rst_st_ready", {31'd0, st_ready}, 32'd1);
        check("rst_misalign", {31'd0, st_misalign}, 32'd0);
        check("rst_ld_hazard", {31'd0, ld_hazard}, 32'd0);
        rst_n    = 1'b1;
        ld_valid = 1'b0;

        // Table-driven single stores with an always-ready memory.
        mem_ack = 1'b1;
        for (int i = 0; i < 10; i++) apply_vec(vecs[i]);

        // Fill to capacity with memory stalled, then attempt one more.
        mem_ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            st_valid  = 1'b1;
            st_addr   = 32'h10 + 32'(4 * i);
            st_data   = 32'(i + 1);
            st_funct3 = 3'b010;
            push_exp(st_addr, st_data, 4'b1111);
        end
        @(posedge clk); #1;
        st_addr = 32'h20;
        st_data = 32'd5;
        @(negedge clk);
        check("full_not_ready", {31'd0, st_ready}, 32'd0);
        @(posedge clk); #1;
        st_valid = 1'b0;
        @(negedge clk);
        check("full_still_not_ready", {31'd0, st_ready}, 32'd0);
        check("full_no_misalign", {31'd0, st_misalign}, 32'd0);
        @(posedge clk); #1;
        mem_ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("drain_b2b_req", {31'd0, mem_req}, 32'd1);
        end
        @(negedge clk);
        check("drained_req", {31'd0, mem_req}, 32'd0);
        check("drained_ready", {31'd0, st_ready}, 32'd1);
        check("drained_empty", {31'd0, empty}, 32'd1);

        // Hazard: a same-cycle push is invisible, pending entries are seen.
        @(posedge clk); #1;
        mem_ack   = 1'b0;
        st_valid  = 1'b1;
        st_addr   = 32'h80;
        st_data   = 32'h0000_0088;
        st_funct3 = 3'b010;
        ld_valid  = 1'b1;
        ld_addr   = 32'h80;
        push_exp(32'h80, 32'h0000_0088, 4'b1111);
        @(negedge clk);
        check("hz_same_cycle", {31'd0, ld_hazard}, 32'd0);
        @(posedge clk); #1;
        st_addr = 32'h40;
        st_data = 32'h0000_0099;
        push_exp(32'h40, 32'h0000_0099, 4'b1111);
        @(negedge clk);
        check("hz_pending_80", {31'd0, ld_hazard}, 32'd1);
        @(posedge clk); #1;
        st_valid = 1'b0;
        ld_addr  = 32'h42;
        @(negedge clk);
        check("hz_42", {31'd0, ld_hazard}, 32'd1);
        @(posedge clk); #1;
        ld_addr = 32'h44;
        @(negedge clk);
        check("hz_44", {31'd0, ld_hazard}, 32'd0);
        @(posedge clk); #1;
        ld_valid = 1'b0;
        ld_addr  = 32'h40;
        @(negedge clk);
        check("hz_no_ld_valid", {31'd0, ld_hazard}, 32'd0);
        @(posedge clk); #1;
        ld_valid = 1'b1;
        mem_ack  = 1'b1;
        @(negedge clk);
        check("hz_40_while_80_writes", {31'd0, ld_hazard}, 32'd1);
        @(negedge clk);
        check("hz_40_while_writing", {31'd0, ld_hazard}, 32'd1);
        @(negedge clk);
        check("hz_40_after_ack", {31'd0, ld_hazard}, 32'd0);
        @(posedge clk); #1;
        mem_ack  = 1'b0;
        ld_valid = 1'b0;
        wait_idle("hz_drain");

        // Asynchronous reset in the middle of a stalled request.
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            st_valid  = 1'b1;
            st_addr   = 32'h50 + 32'(4 * i);
            st_data   = 32'hC0DE_0000 + 32'(i);
            st_funct3 = 3'b010;
        end
        @(posedge clk); #1;
        st_valid = 1'b0;
        ld_valid = 1'b1;
        ld_addr  = 32'h54;
        @(negedge clk);
        check("pre_rst_req", {31'd0, mem_req}, 32'd1);
        check("pre_rst_hazard", {31'd0, ld_hazard}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_req", {31'd0, mem_req}, 32'd0);
        check("midrst_empty", {31'd0, empty}, 32'd1);
        check("midrst_ready", {31'd0, st_ready}, 32'd1);
        check("midrst_hazard", {31'd0, ld_hazard}, 32'd0);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        mem_ack  = 1'b1;
        ld_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("post_rst_quiet", {30'd0, mem_req, empty}, 32'd1);
        end
        apply_vec('{32'h0000_0060, 32'h0000_0011, 3'b000, 1'b0, 4'b0001, 32'h1111_1111});

        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/store_buffer.md
Name: store_buffer

Overview:
Downstream of mux_st in the memory stage: consumes the formatted store data and the store's funct3 and effective address. Aligns data to byte lanes and generates byte enables. Queues up to DEPTH pending stores and drains them in order to data memory over a req/ack handshake, so the pipeline need not stall on memory write latency. Flags misaligned or illegal stores, and raises a load hazard when a load targets a word that still has a pending store.

Parameters:
DEPTH, 4, number of buffered stores (power of two, at least 2)
AW, 32, address width
DW, 32, data width (fixed 32; byte-lane logic assumes 4 lanes)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
st_valid  input  1  store request this cycle
st_ready  output  1  buffer can accept a store (not full)
st_addr  input  AW  store effective address
st_data  input  DW  store data from mux_st (low bits significant)
st_funct3  input  3  RV32I store funct3
st_misalign  output  1  one-cycle pulse: store rejected (misaligned or illegal size)
ld_valid  input  1  load in memory stage
ld_addr  input  AW  load effective address
ld_hazard  output  1  pending store to the same word as the load
mem_req  output  1  write request to data memory
mem_addr  output  AW  word-aligned write address ({addr[AW-1:2],2'b00})
mem_wdata  output  DW  lane-aligned write data
mem_be  output  4  byte enables
mem_ack  input  1  memory accepted the write
empty  output  1  no pending stores (used for fence/flush)

Behaviour:
- Size decode from st_funct3[1:0]: 00 = SB, 01 = SH, 10 = SW, 11 = illegal. st_funct3[2] is ignored.
- Lane alignment, with off = st_addr[1:0]:
  - SB: be = 4'b0001 << off; wdata = {4{st_data[7:0]}}.
  - SH: be = 4'b0011 << off; wdata = {2{st_data[15:0]}}.
  - SW: be = 4'b1111; wdata = st_data.
  - Unused lanes are don't-care, but the bench checks the replication above.
- Reject conditions: SH with off[0] = 1, SW with off != 0, or size 11.
  - On a rejected store with st_valid high, st_misalign = 1 in the next cycle (registered, one cycle) and no entry is written.
  - st_misalign is asserted even if st_ready is low.
- Accept: push when st_valid && st_ready && aligned. Each entry stores {word address, wdata, be}.
- st_ready = (count != DEPTH). It is combinational from registered count.
  - No full-bypass: when full, a store is not accepted even if a pop occurs in the same cycle.
- Drain FSM, two states:
  - IDLE: mem_req = 0. Go to REQ on the next edge when count != 0 (including an entry pushed this cycle becoming visible next cycle).
  - REQ: mem_req = 1. mem_addr, mem_wdata and mem_be are driven from the head entry and held stable until mem_ack.
  - On mem_ack in REQ: pop the head. Stay in REQ if entries remain after the pop (counting a simultaneous push); otherwise go to IDLE.
  - Back-to-back ack gives one write per cycle.
- mem_ack outside REQ is ignored.
- Latency: a store accepted at edge N gives mem_req high at edge N+1 if the buffer was empty and idle.
- Simultaneous push and pop: count unchanged, pointers both advance. Pointers wrap modulo DEPTH. Order is strict FIFO.
- ld_hazard (combinational) = ld_valid && any valid entry with entry word address == ld_addr[AW-1:2]. This includes the entry currently being written until its ack edge. It excludes a store pushed in the same cycle.
- empty = (count == 0). It is low while in REQ.
- Reset (asynchronous, any time, including mid-request): count, pointers and st_misalign go to 0, FSM goes to IDLE, so mem_req = 0. st_ready = 1, empty = 1, ld_hazard = 0. Entry contents are not reset. A write in flight is abandoned.

Decomposition:
- Shared package (rv_pkg): store size constants SZ_B = 2'b00, SZ_H = 2'b01, SZ_W = 2'b10; drain FSM state encoding; DEPTH default.
- Sub-module store_lane_align: combinational {st_data, funct3, off} -> {wdata, be, misalign}. It is reusable by the load path's lane extraction tests.
- FIFO storage, FSM and hazard compare stay in store_buffer.

Test Plan:
- SB: addr 0x0000_0103, data 0x0000_00AB, mem_ack = 1 -> next cycle mem_req = 1, mem_addr 0x0000_0100, mem_be 4'b1000, mem_wdata 0xABABABAB; then empty = 1.
- SH: addr 0x0000_0202, data 0xFFFF_F0EE (mux_st output) -> mem_be 4'b1100, mem_wdata 0xF0EEF0EE.
- Misaligned and illegal:
  - SW at 0x0000_0101 -> st_misalign one-cycle pulse, mem_req stays 0, empty stays 1.
  - funct3 = 3'b011 at 0x0 -> same result.
- Fill and drain:
  - Four SWs (0x10, 0x14, 0x18, 0x1C; data 1..4) with mem_ack = 0 -> st_ready = 0 after the 4th; a 5th store is not accepted.
  - Then hold mem_ack = 1 -> four consecutive write cycles in order, then mem_req = 0 and st_ready = 1.
- Hazard: pending SW at 0x40, ld_valid with ld_addr 0x42 -> ld_hazard = 1; ld_addr 0x44 -> 0; after the 0x40 ack edge -> 0.
- Reset mid-operation: two entries pending, mem_req = 1; pulse rst_n low between edges -> mem_req = 0, empty = 1, st_ready = 1 immediately; no write is issued after release until a new store arrives.
